vga_sync_receiver: RTL and testbench

- Receive-side counterpart of the VGA timing chain: consumes a pixel-rate HSYNC/VSYNC stream and recovers pixel X/Y coordinates and the active-video flag.
- Checks line and frame lengths against nominal timing and reports lock state plus sticky length errors.
- Sits on the capture/loopback path of the AHB VGA peripheral, one PIX_EN strobe per pixel, same clock domain as the sync generator.

---
 rtl/vga_rx_pkg.sv | 32 +++
 rtl/sync_edge_detect.sv | 36 +++
 rtl/vga_sync_receiver.sv | 196 +++++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_rx_pkg.sv
// rtl/vga_rx_pkg.sv - shared state type, default 640x480 timing and derived totals for the VGA sync receiver
//
// Purpose: types and constants imported by vga_sync_receiver and its helpers.
// Ports: none (package).

package vga_rx_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_H_LOCKED = 2'd1,
    ST_LOCKED   = 2'd2
  } rx_state_e;

  // Default 640x480@60 timing, in pixels / lines
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - polarity-normalised sync assertion-edge detector with gated history
//
// Purpose: normalises a sync input to active-high, keeps the previous normalised
// level (updated only when en_i=1) and flags an assertion edge on enabled cycles.
// Ports:
//   CLK, RESET : clock, asynchronous active-high reset
//   en_i       : sample enable; history register updates only when high
//   sync_i     : raw sync input, active level given by POL
//   edge_o     : combinational, high when en_i=1, level asserted and previous level not

module sync_edge_detect #(
  parameter bit POL = 1'b0
) (
  input  logic CLK,
  input  logic RESET,
  input  logic en_i,
  input  logic sync_i,
  output logic edge_o
);

  logic level;
  logic prev_q;

  assign level = (sync_i == POL);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prev_q <= 1'b0;
    end else if (en_i) begin
      prev_q <= level;
    end
  end

  assign edge_o = en_i & level & ~prev_q;

endmodule

// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - recovers X/Y/active from a pixel-rate HSYNC/VSYNC stream and checks timing lock
//
// Purpose: tracks horizontal/vertical position from sync edges, reports the active
// window coordinates, lock state and sticky line/frame length errors.
// Ports:
//   CLK, RESET      : clock, asynchronous active-high reset
//   PIX_EN          : pixel strobe; everything holds when low
//   HSYNC_IN        : horizontal sync, active level HS_POL
//   VSYNC_IN        : vertical sync, active level VS_POL
//   ERR_CLR         : synchronous clear of the sticky error flags
//   X, Y            : active-window coordinates, 0 outside the window
//   ACTIVE          : sample is inside the active window while locked
//   LOCKED          : full horizontal + vertical lock
//   LINE_DONE       : one-CLK pulse per hsync assertion edge
//   FRAME_DONE      : one-CLK pulse per vsync assertion edge
//   LINE_LEN_ERR    : sticky bad line length
//   FRAME_LEN_ERR   : sticky bad frame length

module vga_sync_receiver
  import vga_rx_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HCNT_W   = 10,
  parameter int VCNT_W   = 10,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              PIX_EN,
  input  logic              HSYNC_IN,
  input  logic              VSYNC_IN,
  input  logic              ERR_CLR,
  output logic [HCNT_W-1:0] X,
  output logic [VCNT_W-1:0] Y,
  output logic              ACTIVE,
  output logic              LOCKED,
  output logic              LINE_DONE,
  output logic              FRAME_DONE,
  output logic              LINE_LEN_ERR,
  output logic              FRAME_LEN_ERR
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [HCNT_W-1:0] H_LAST  = HCNT_W'(H_TOTAL - 1);
  localparam logic [HCNT_W-1:0] H_START = HCNT_W'(H_SYNC + H_BP);
  localparam logic [HCNT_W-1:0] H_END   = HCNT_W'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [HCNT_W-1:0] H_MAX   = '1;
  localparam logic [VCNT_W-1:0] V_LAST  = VCNT_W'(V_TOTAL - 1);
  localparam logic [VCNT_W-1:0] V_START = VCNT_W'(V_SYNC + V_BP);
  localparam logic [VCNT_W-1:0] V_END   = VCNT_W'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [VCNT_W-1:0] V_MAX   = '1;

  logic              hs_edge;
  logic              vs_edge;
  logic [HCNT_W-1:0] hpos_q, hpos_d;
  logic [VCNT_W-1:0] vpos_q, vpos_d;
  rx_state_e         state_q, state_d;
  logic              armed_q, armed_d;
  logic              line_err;
  logic              frame_err;
  logic              active_d;
  logic [HCNT_W-1:0] x_d;
  logic [VCNT_W-1:0] y_d;
  logic              line_len_err_d;
  logic              frame_len_err_d;

  sync_edge_detect #(.POL(HS_POL)) u_hs_edge (
    .CLK    (CLK),
    .RESET  (RESET),
    .en_i   (PIX_EN),
    .sync_i (HSYNC_IN),
    .edge_o (hs_edge)
  );

  // VSYNC is only looked at once per line, on the hsync edge, so a vsync edge
  // always coincides with the first pixel of a line.
  sync_edge_detect #(.POL(VS_POL)) u_vs_edge (
    .CLK    (CLK),
    .RESET  (RESET),
    .en_i   (hs_edge),
    .sync_i (VSYNC_IN),
    .edge_o (vs_edge)
  );

  always_comb begin
    hpos_d    = hpos_q;
    vpos_d    = vpos_q;
    state_d   = state_q;
    armed_d   = armed_q;
    line_err  = 1'b0;
    frame_err = 1'b0;

    if (PIX_EN) begin
      if (hs_edge) begin
        hpos_d = '0;
      end else if (hpos_q != H_MAX) begin
        hpos_d = hpos_q + HCNT_W'(1);
      end

      if (hs_edge) begin
        if (vs_edge) begin
          vpos_d = '0;
        end else if (vpos_q != V_MAX) begin
          vpos_d = vpos_q + VCNT_W'(1);
        end
      end

      // Early edge or missing edge, judged against the position before this sample
      if (state_q != ST_UNLOCKED) begin
        line_err = hs_edge ? (hpos_q != H_LAST) : (hpos_q == H_LAST);
      end
      if (state_q == ST_LOCKED && hs_edge) begin
        frame_err = vs_edge ? (vpos_q != V_LAST) : (vpos_q == V_LAST);
      end

      case (state_q)
        ST_UNLOCKED: begin
          // armed_q stays set after the first edge, so the edge that caused
          // an error also serves as the reference for relocking.
          if (hs_edge) begin
            armed_d = 1'b1;
            if (armed_q && hpos_q == H_LAST) begin
              state_d = ST_H_LOCKED;
            end
          end
        end
        ST_H_LOCKED: begin
          if (line_err) begin
            state_d = ST_UNLOCKED;
          end else if (vs_edge) begin
            state_d = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (line_err) begin
            state_d = ST_UNLOCKED;
          end else if (frame_err) begin
            state_d = ST_H_LOCKED;
          end
        end
        default: state_d = ST_UNLOCKED;
      endcase
    end

    active_d = (hpos_d >= H_START) && (hpos_d <= H_END) &&
               (vpos_d >= V_START) && (vpos_d <= V_END) &&
               (state_d == ST_LOCKED);
    x_d = active_d ? (hpos_d - H_START) : '0;
    y_d = active_d ? (vpos_d - V_START) : '0;

    // A new error wins over a concurrent clear
    line_len_err_d  = line_err  | (LINE_LEN_ERR  & ~ERR_CLR);
    frame_len_err_d = frame_err | (FRAME_LEN_ERR & ~ERR_CLR);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hpos_q        <= '0;
      vpos_q        <= '0;
      state_q       <= ST_UNLOCKED;
      armed_q       <= 1'b0;
      X             <= '0;
      Y             <= '0;
      ACTIVE        <= 1'b0;
      LOCKED        <= 1'b0;
      LINE_DONE     <= 1'b0;
      FRAME_DONE    <= 1'b0;
      LINE_LEN_ERR  <= 1'b0;
      FRAME_LEN_ERR <= 1'b0;
    end else begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      state_q       <= state_d;
      armed_q       <= armed_d;
      X             <= x_d;
      Y             <= y_d;
      ACTIVE        <= active_d;
      LOCKED        <= (state_d == ST_LOCKED);
      LINE_DONE     <= hs_edge;
      FRAME_DONE    <= vs_edge;
      LINE_LEN_ERR  <= line_len_err_d;
      FRAME_LEN_ERR <= frame_len_err_d;
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb/tb_vga_sync_receiver.sv - directed self-checking bench for vga_sync_receiver on reduced timing

module tb_vga_sync_receiver;

  // Reduced timing: H_TOTAL = 16, V_TOTAL = 11; active hpos 6..13, vpos 4..9
  localparam int HA = 8, HF = 2, HSW = 3, HB = 3;
  localparam int VA = 6, VF = 1, VSW = 2, VB = 2;
  localparam int HT = 16, VT = 11;

  logic clk = 1'b0;
  logic reset, pix_en, hs, vs, err_clr;

  logic [9:0] x_a, y_a, x_b, y_b;
  logic act_a, lk_a, ld_a, fd_a, lle_a, fle_a;
  logic act_b, lk_b, ld_b, fd_b, lle_b, fle_b;

  int  checks = 0;
  int  failures = 0;
  bit  probe_en = 1'b0;
  bit  exp_locked = 1'b0;
  bit  saw_ld = 1'b0;

  always #5 clk = ~clk;

  vga_sync_receiver #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HCNT_W(10), .VCNT_W(10), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_a (
    .CLK(clk), .RESET(reset), .PIX_EN(pix_en), .HSYNC_IN(hs), .VSYNC_IN(vs),
    .ERR_CLR(err_clr), .X(x_a), .Y(y_a), .ACTIVE(act_a), .LOCKED(lk_a),
    .LINE_DONE(ld_a), .FRAME_DONE(fd_a), .LINE_LEN_ERR(lle_a), .FRAME_LEN_ERR(fle_a)
  );

  vga_sync_receiver #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HCNT_W(10), .VCNT_W(10), .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_b (
    .CLK(clk), .RESET(reset), .PIX_EN(pix_en), .HSYNC_IN(~hs), .VSYNC_IN(~vs),
    .ERR_CLR(err_clr), .X(x_b), .Y(y_b), .ACTIVE(act_b), .LOCKED(lk_b),
    .LINE_DONE(ld_b), .FRAME_DONE(fd_b), .LINE_LEN_ERR(lle_b), .FRAME_LEN_ERR(fle_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_both(input string tag, input logic [31:0] ga, input logic [31:0] gb,
                            input logic [31:0] exp);
    check_eq({tag, "_a"}, ga, exp);
    check_eq({tag, "_b"}, gb, exp);
  endtask

  task automatic check_status(input string tag, input int locked, input int lle, input int fle);
    check_both({tag, "_locked"}, lk_a, lk_b, locked);
    check_both({tag, "_line_err"}, lle_a, lle_b, lle);
    check_both({tag, "_frame_err"}, fle_a, fle_b, fle);
  endtask

  task automatic check_xya(input string tag, input int x, input int y, input int act);
    check_both({tag, "_x"}, x_a, x_b, x);
    check_both({tag, "_y"}, y_a, y_b, y);
    check_both({tag, "_active"}, act_a, act_b, act);
  endtask

  task automatic check_all_zero(input string tag);
    check_xya(tag, 0, 0, 0);
    check_status(tag, 0, 0, 0);
    check_both({tag, "_line_done"}, ld_a, ld_b, 0);
    check_both({tag, "_frame_done"}, fd_a, fd_b, 0);
  endtask

  task automatic probe(input int h, input int v);
    if (h == 0 && v == 0) begin
      check_both("sol_line_done", ld_a, ld_b, 1);
      check_both("sof_frame_done", fd_a, fd_b, 1);
    end
    if (h == 1 && v == 0) begin
      check_both("line_done_pulse", ld_a, ld_b, 0);
      check_both("frame_done_pulse", fd_a, fd_b, 0);
    end
    if (h == 5 && v == 4) check_both("pre_window_active", act_a, act_b, 0);
    if (h == 6 && v == 4) begin
      check_xya("first_px", 0, 0, exp_locked);
      check_both("first_px_locked", lk_a, lk_b, exp_locked);
    end
    if (h == 13 && v == 9) check_xya("last_px", exp_locked ? 7 : 0, exp_locked ? 5 : 0, exp_locked);
    if (h == 14 && v == 9) check_xya("post_window", 0, 0, 0);
  endtask

  task automatic pixel(input int h, input int v);
    pix_en = 1'b1;
    hs = (h < HSW) ? 1'b0 : 1'b1;
    vs = (v < VSW) ? 1'b0 : 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic line(input int v, input int h0, input int h1);
    for (int h = h0; h < h1; h++) begin
      pixel(h, v);
      if (probe_en) probe(h, v);
    end
  endtask

  task automatic lines(input int v0, input int v1);
    for (int v = v0; v < v1; v++) line(v, 0, HT);
  endtask

  task automatic idle(input int n);
    pix_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      hs = ~hs;
      @(posedge clk);
      #1;
      if (ld_a || ld_b) saw_ld = 1'b1;
    end
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pix_en = 1'b0; hs = 1'b1; vs = 1'b1; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Nominal stream, both polarities, 3 frames
    probe_en = 1'b1;
    exp_locked = 1'b0;
    lines(0, VT);
    exp_locked = 1'b1;
    lines(0, VT);
    lines(0, VT);
    probe_en = 1'b0;
    check_status("nominal_end", 1, 0, 0);

    // Short line while locked, then relock
    line(0, 0, HT);
    line(1, 0, HT - 1);
    line(2, 0, 1);
    check_status("short_line", 0, 1, 0);
    line(2, 1, HT);
    line(3, 0, 1);
    check_status("relock_h", 0, 1, 0);
    line(3, 1, HT);
    lines(4, VT);
    line(0, 0, 1);
    check_status("relock_v", 1, 1, 0);
    line(0, 1, HT);
    err_clr = 1'b1;
    line(1, 0, 1);
    err_clr = 1'b0;
    check_status("err_clr", 1, 0, 0);
    line(1, 1, HT - 1);
    err_clr = 1'b1;
    line(2, 0, 1);
    err_clr = 1'b0;
    check_status("clr_vs_set", 0, 1, 0);
    line(2, 1, HT);
    lines(3, VT);
    clear_errs();
    check_status("clr_again", 0, 0, 0);

    // Short frame while locked
    line(0, 0, 1);
    check_status("frame_c_lock", 1, 0, 0);
    line(0, 1, HT);
    lines(1, VT - 1);
    line(0, 0, 1);
    check_status("short_frame", 0, 0, 1);
    line(0, 1, HT);
    lines(1, VT);
    line(0, 0, 1);
    check_status("frame_relock", 1, 0, 1);
    clear_errs();
    check_status("frame_clr", 1, 0, 0);

    // PIX_EN held low mid-line with HSYNC toggling
    line(0, 1, HT);
    lines(1, 4);
    line(4, 0, 8);
    check_xya("pre_stall", 1, 0, 1);
    saw_ld = 1'b0;
    idle(100);
    check_eq("stall_no_line_done", saw_ld, 0);
    check_xya("stall_frozen", 1, 0, 1);
    line(4, 8, 9);
    check_xya("resume", 2, 0, 1);
    line(4, 9, HT);
    lines(5, VT);
    check_status("post_stall", 1, 0, 0);

    // Asynchronous reset mid-frame
    lines(0, 5);
    line(5, 0, 9);
    check_xya("pre_reset", 2, 1, 1);
    #2 reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    line(5, 9, HT);
    line(6, 0, 1);
    check_status("rst_arm", 0, 0, 0);
    line(6, 1, HT);
    line(7, 0, 1);
    check_status("rst_hlock", 0, 0, 0);
    line(7, 1, HT);
    lines(8, VT);
    line(0, 0, 1);
    check_status("rst_relock", 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
